wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Receiving end of the MEM-stage writeback interface (write_data/addr/en + HI/LO).
//  Holds the MEM/WB pipeline latch, commits it into the 32x32 GPR file and HI/LO pair,
//  and serves two combinational ID-stage read ports with same-cycle writeback bypass.
//  Sits between MEM and ID; it is the only writer of architectural register state.
// PARAMETERS
//  DATA_W    32  register / data width (matches REG_DATA_BUS)
//  ADDR_W    5   register address width (matches REG_ADDR_BUS)
//  NUM_REGS  32  GPR count; index 0 hardwired to zero
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       asynchronous, active-high reset
//  stall_i      in   1       hold MEM/WB latch contents
//  flush_i      in   1       kill MEM/WB latch (clear valid)
//  write_data_i in   DATA_W  MEM-stage writeback data
//  write_addr_i in   ADDR_W  MEM-stage destination register
//  write_en_i   in   1       MEM-stage GPR write enable
//  hi_i / lo_i  in   DATA_W  MEM-stage HI/LO data
//  whilo_i      in   1       MEM-stage HI/LO write enable
//  re1_i/re2_i  in   1       read-port enables
//  raddr1_i/2_i in   ADDR_W  read addresses
//  rdata1_o/2_o out  DATA_W  read data (combinational)
//  hi_o / lo_o  out  DATA_W  current HI/LO (bypassed)
//  commit_en_o  out  1       WB latch holds a GPR write this cycle
//  commit_addr_o out ADDR_W  WB latch destination
//  commit_data_o out DATA_W  WB latch data
// BEHAVIOUR
//  Reset (async, rst=1): WB latch, all GPRs, HI, LO = 0; all outputs 0 while rst high.
//  WB latch per edge, priority: flush_i -> wb_en=0, wb_whilo=0 (data don't-care);
//   else stall_i -> hold; else capture all *_i inputs. flush beats stall when both high.
//  Commit per edge: if wb_en && wb_addr!=0 -> gpr[wb_addr]<=wb_data;
//   if wb_whilo -> HI<=wb_hi, LO<=wb_lo. Commit happens even while stall_i high
//   (latch held => same value rewritten, idempotent).
//  Latency: input at MEM in cycle N -> in latch cycle N+1 (visible via bypass)
//   -> in array from cycle N+2.
//  Read port k: re_k=0 -> 0; raddr=0 -> 0; wb_en && wb_addr==raddr -> wb_data (bypass);
//   else gpr[raddr]. hi_o/lo_o: wb_whilo ? wb_hi/wb_lo : HI/LO.
//  Writes to $0 are discarded; never bypass $0.
//  commit_*_o are direct latch views; commit_en_o = wb_en && wb_addr!=0.
//  Reset mid-pipeline: in-flight writeback lost, no partial commit.
//  No combinational path from *_i writeback inputs to any output.
// STRUCTURE
//  Shared package/header: REG_DATA_BUS, REG_ADDR_BUS, REG_NUM, ZERO_WORD,
//   REG_ZERO_ADDR constants (extend existing regfile defines).
//  Sub-module gpr_array: NUM_REGS storage, one write port, two bypassed read ports,
//   async reset; wb_regfile adds MEM/WB latch, stall/flush control, HI/LO.
// TESTING
//  1 write $5=0xDEADBEEF at MEM, no stall -> commit_en=1 next cycle; raddr1=5 returns
//    0xDEADBEEF via bypass that cycle and from array the cycle after.
//  2 write $0=0x12345678 -> commit_en_o=0, raddr1=0 reads 0 always.
//  3 stall_i high 3 cycles with new MEM input 0x11 to $7 -> latch keeps old value;
//    $7 takes 0x11 only after stall drops.
//  4 flush_i and stall_i both high with pending write $9=0xAA -> $9 unchanged, commit_en=0.
//  5 whilo_i=1 hi=0x1, lo=0x2 -> hi_o/lo_o =1/2 one cycle later, persist after whilo drops.
//  6 rst pulse mid-run after filling $1..$31 -> all reads 0, hi_o/lo_o=0, commit_en_o=0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared register-file constants for the MEM/WB writeback block and its GPR array.
package wb_regfile_pkg;
  localparam int               REG_DATA_BUS  = 32;
  localparam int               REG_ADDR_BUS  = 5;
  localparam int               REG_NUM       = 32;
  localparam logic [31:0]      ZERO_WORD     = 32'h0000_0000;
  localparam logic [4:0]       REG_ZERO_ADDR = 5'd0;
endpackage

// File: rtl/wb_regfile_if.sv
// Writeback / read-port bundle between MEM, ID and the register file.
// Signal names keep the regfile-side _i/_o suffixes so both ends trace to one list.
interface wb_regfile_if #(
  parameter int DATA_W = wb_regfile_pkg::REG_DATA_BUS,
  parameter int ADDR_W = wb_regfile_pkg::REG_ADDR_BUS
);
  logic              stall_i;
  logic              flush_i;
  logic [DATA_W-1:0] write_data_i;
  logic [ADDR_W-1:0] write_addr_i;
  logic              write_en_i;
  logic [DATA_W-1:0] hi_i;
  logic [DATA_W-1:0] lo_i;
  logic              whilo_i;
  logic              re1_i;
  logic              re2_i;
  logic [ADDR_W-1:0] raddr1_i;
  logic [ADDR_W-1:0] raddr2_i;
  logic [DATA_W-1:0] rdata1_o;
  logic [DATA_W-1:0] rdata2_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic              commit_en_o;
  logic [ADDR_W-1:0] commit_addr_o;
  logic [DATA_W-1:0] commit_data_o;

  // Register file side
  modport slave (
    input  stall_i, flush_i, write_data_i, write_addr_i, write_en_i,
           hi_i, lo_i, whilo_i, re1_i, re2_i, raddr1_i, raddr2_i,
    output rdata1_o, rdata2_o, hi_o, lo_o, commit_en_o, commit_addr_o, commit_data_o
  );

  // Pipeline (MEM/ID) side
  modport master (
    output stall_i, flush_i, write_data_i, write_addr_i, write_en_i,
           hi_i, lo_i, whilo_i, re1_i, re2_i, raddr1_i, raddr2_i,
    input  rdata1_o, rdata2_o, hi_o, lo_o, commit_en_o, commit_addr_o, commit_data_o
  );
endinterface

// File: rtl/wb_regfile_gpr_array.sv
// GPR storage: one write port, two read ports with same-cycle write bypass.
// Entry 0 is never written and reads always return zero for address 0.
module gpr_array
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_BUS,
  parameter int ADDR_W   = REG_ADDR_BUS,
  parameter int NUM_REGS = REG_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o
);
  localparam logic [DATA_W-1:0] ZERO  = DATA_W'(ZERO_WORD);
  localparam logic [ADDR_W-1:0] RZERO = ADDR_W'(REG_ZERO_ADDR);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic              wr_ok;

  // A write to $0 is dropped here so callers need not filter it
  assign wr_ok = we_i && (waddr_i != RZERO);

  // Storage update; slot 0 stays at its reset value forever
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= ZERO;
    end else begin
      for (int i = 1; i < NUM_REGS; i++)
        if (wr_ok && (waddr_i == ADDR_W'(i))) mem_q[i] <= wdata_i;
    end
  end

  // Read port 1: disabled/$0 -> 0, pending write wins over stored value
  always_comb begin
    rdata1_o = ZERO;
    if (re1_i && (raddr1_i != RZERO)) begin
      if (wr_ok && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
      else                                rdata1_o = mem_q[raddr1_i];
    end
  end

  // Read port 2: same rules as port 1
  always_comb begin
    rdata2_o = ZERO;
    if (re2_i && (raddr2_i != RZERO)) begin
      if (wr_ok && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
      else                                rdata2_o = mem_q[raddr2_i];
    end
  end
endmodule

// File: rtl/wb_regfile.sv
// MEM/WB latch plus architectural GPR and HI/LO state. Everything visible on the
// outputs comes from the latch or the arrays, never straight from MEM inputs.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_BUS,
  parameter int ADDR_W   = REG_ADDR_BUS,
  parameter int NUM_REGS = REG_NUM
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);
  localparam logic [DATA_W-1:0] ZERO  = DATA_W'(ZERO_WORD);
  localparam logic [ADDR_W-1:0] RZERO = ADDR_W'(REG_ZERO_ADDR);

  logic              wb_en_q,    wb_en_d;
  logic [ADDR_W-1:0] wb_addr_q,  wb_addr_d;
  logic [DATA_W-1:0] wb_data_q,  wb_data_d;
  logic              wb_whilo_q, wb_whilo_d;
  logic [DATA_W-1:0] wb_hi_q,    wb_hi_d;
  logic [DATA_W-1:0] wb_lo_q,    wb_lo_d;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic              commit_en;

  // Latch next state: flush kills, else stall holds, else take MEM inputs
  always_comb begin
    wb_en_d    = wb_en_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    wb_whilo_d = wb_whilo_q;
    wb_hi_d    = wb_hi_q;
    wb_lo_d    = wb_lo_q;
    if (bus.flush_i) begin
      wb_en_d    = 1'b0;
      wb_whilo_d = 1'b0;
    end else if (!bus.stall_i) begin
      wb_en_d    = bus.write_en_i;
      wb_addr_d  = bus.write_addr_i;
      wb_data_d  = bus.write_data_i;
      wb_whilo_d = bus.whilo_i;
      wb_hi_d    = bus.hi_i;
      wb_lo_d    = bus.lo_i;
    end
  end

  // MEM/WB latch register; reset drops any in-flight writeback
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_q    <= 1'b0;
      wb_addr_q  <= RZERO;
      wb_data_q  <= ZERO;
      wb_whilo_q <= 1'b0;
      wb_hi_q    <= ZERO;
      wb_lo_q    <= ZERO;
    end else begin
      wb_en_q    <= wb_en_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      wb_whilo_q <= wb_whilo_d;
      wb_hi_q    <= wb_hi_d;
      wb_lo_q    <= wb_lo_d;
    end
  end

  // HI/LO commit; rewriting the same held value during a stall is harmless
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= ZERO;
      lo_q <= ZERO;
    end else if (wb_whilo_q) begin
      hi_q <= wb_hi_q;
      lo_q <= wb_lo_q;
    end
  end

  assign commit_en = wb_en_q && (wb_addr_q != RZERO);

  gpr_array #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_gpr (
    .clk      (clk),
    .rst      (rst),
    .we_i     (commit_en),
    .waddr_i  (wb_addr_q),
    .wdata_i  (wb_data_q),
    .re1_i    (bus.re1_i),
    .raddr1_i (bus.raddr1_i),
    .rdata1_o (bus.rdata1_o),
    .re2_i    (bus.re2_i),
    .raddr2_i (bus.raddr2_i),
    .rdata2_o (bus.rdata2_o)
  );

  assign bus.hi_o          = wb_whilo_q ? wb_hi_q : hi_q;
  assign bus.lo_o          = wb_whilo_q ? wb_lo_q : lo_q;
  assign bus.commit_en_o   = commit_en;
  assign bus.commit_addr_o = wb_addr_q;
  assign bus.commit_data_o = wb_data_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: bypass/latency, $0, stall, flush, HI/LO, reset.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled there too
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_wr(input logic [4:0] a, input logic [31:0] d);
    bus.write_en_i   = 1'b1;
    bus.write_addr_i = a;
    bus.write_data_i = d;
  endtask

  initial begin
    bus.stall_i = 0; bus.flush_i = 0;
    bus.write_en_i = 0; bus.write_addr_i = '0; bus.write_data_i = '0;
    bus.whilo_i = 0; bus.hi_i = '0; bus.lo_i = '0;
    bus.re1_i = 1; bus.re2_i = 1; bus.raddr1_i = 5'd5; bus.raddr2_i = 5'd7;

    // Reset state
    #12;
    chk("rst_rdata1", bus.rdata1_o, 32'h0);
    chk("rst_hi", bus.hi_o, 32'h0);
    chk("rst_commit_en", {31'b0, bus.commit_en_o}, 32'h0);
    step();
    rst = 1'b0;
    step();

    // 1: $5 = DEADBEEF, bypass then array
    mem_wr(5'd5, 32'hDEADBEEF);
    #2;
    chk("t1_no_comb_path", bus.rdata1_o, 32'h0);
    step();
    bus.write_en_i = 0;
    chk("t1_commit_en", {31'b0, bus.commit_en_o}, 32'h1);
    chk("t1_commit_addr", {27'b0, bus.commit_addr_o}, 32'd5);
    chk("t1_commit_data", bus.commit_data_o, 32'hDEADBEEF);
    chk("t1_bypass", bus.rdata1_o, 32'hDEADBEEF);
    step();
    chk("t1_array", bus.rdata1_o, 32'hDEADBEEF);
    chk("t1_commit_off", {31'b0, bus.commit_en_o}, 32'h0);
    bus.re1_i = 0;
    #1;
    chk("t1_re_off", bus.rdata1_o, 32'h0);
    bus.re1_i = 1;

    // 2: write to $0 is dropped
    bus.raddr1_i = 5'd0;
    mem_wr(5'd0, 32'h12345678);
    step();
    bus.write_en_i = 0;
    chk("t2_commit_en", {31'b0, bus.commit_en_o}, 32'h0);
    chk("t2_r0_latch", bus.rdata1_o, 32'h0);
    step();
    chk("t2_r0_array", bus.rdata1_o, 32'h0);

    // 3: stall holds old $7 write while MEM offers 0x11
    mem_wr(5'd7, 32'h55);
    step();
    chk("t3_pre", bus.rdata2_o, 32'h55);
    bus.stall_i = 1;
    mem_wr(5'd7, 32'h11);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_stall_data", bus.commit_data_o, 32'h55);
      chk("t3_stall_read", bus.rdata2_o, 32'h55);
    end
    bus.stall_i = 0;
    step();
    bus.write_en_i = 0;
    chk("t3_release_bypass", bus.rdata2_o, 32'h11);
    step();
    chk("t3_release_array", bus.rdata2_o, 32'h11);

    // 4: flush beats stall for pending $9 write
    bus.raddr1_i = 5'd9;
    bus.stall_i = 1; bus.flush_i = 1;
    mem_wr(5'd9, 32'hAA);
    step();
    chk("t4_commit_en", {31'b0, bus.commit_en_o}, 32'h0);
    chk("t4_r9", bus.rdata1_o, 32'h0);
    bus.stall_i = 0; bus.flush_i = 0; bus.write_en_i = 0;
    step();
    step();
    chk("t4_r9_later", bus.rdata1_o, 32'h0);
    chk("t4_r7_kept", bus.rdata2_o, 32'h11);

    // 5: HI/LO write, then persistence
    bus.whilo_i = 1; bus.hi_i = 32'h1; bus.lo_i = 32'h2;
    step();
    chk("t5_hi", bus.hi_o, 32'h1);
    chk("t5_lo", bus.lo_o, 32'h2);
    bus.hi_i = 32'h33; bus.lo_i = 32'h44;
    #1;
    chk("t5_no_comb_hi", bus.hi_o, 32'h1);
    bus.whilo_i = 0;
    step();
    step();
    chk("t5_hi_persist", bus.hi_o, 32'h1);
    chk("t5_lo_persist", bus.lo_o, 32'h2);

    // 6: fill $1..$31, then reset with a write in flight
    for (int i = 1; i < 32; i++) begin
      mem_wr(5'(i), 32'h01010101 * i);
      step();
    end
    bus.write_en_i = 0;
    step();
    bus.raddr1_i = 5'd1; bus.raddr2_i = 5'd31;
    #1;
    chk("t6_r1", bus.rdata1_o, 32'h01010101);
    chk("t6_r31", bus.rdata2_o, 32'h1F1F1F1F);
    mem_wr(5'd3, 32'hFFFF);
    step();
    bus.write_en_i = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_r1", bus.rdata1_o, 32'h0);
    chk("t6_rst_r31", bus.rdata2_o, 32'h0);
    chk("t6_rst_hi", bus.hi_o, 32'h0);
    chk("t6_rst_lo", bus.lo_o, 32'h0);
    chk("t6_rst_commit", {31'b0, bus.commit_en_o}, 32'h0);
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 32; i++) begin
      bus.raddr1_i = 5'(i);
      #1;
      chk("t6_post_rst", bus.rdata1_o, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
